// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/host arbiter and sequencer for a single-port synchronous data memory
module dmem_arbiter #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 12,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_ack,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  last_grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic                    mem_wren_q, mem_wren_d;
  logic                    owner_q, owner_d;   // 1 = host owns the transaction in flight
  logic                    op_we_q, op_we_d;
  logic                    last_grant_q, last_grant_d;
  logic                    core_ack_q, core_ack_d;
  logic                    host_ack_q, host_ack_d;
  logic [DATA_WIDTH-1:0]   core_rdata_q, core_rdata_d;
  logic [DATA_WIDTH-1:0]   host_rdata_q, host_rdata_d;
  logic                    grant_host;

  // Winner selection among requesters sampled in IDLE
  always_comb begin
    if (FIXED_PRIORITY != 0) begin
      grant_host = !core_req;
    end else begin
      grant_host = host_req && (!core_req || !last_grant_q);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = mem_wren_q;
    owner_d       = owner_q;
    op_we_d       = op_we_q;
    last_grant_d  = last_grant_q;
    core_ack_d    = 1'b0;
    host_ack_d    = 1'b0;
    core_rdata_d  = core_rdata_q;
    host_rdata_d  = host_rdata_q;
    case (state_q)
      IDLE: begin
        if (core_req || host_req) begin
          owner_d       = grant_host;
          last_grant_d  = grant_host;
          op_we_d       = grant_host ? host_we : core_we;
          mem_wren_d    = grant_host ? host_we : core_we;
          mem_address_d = grant_host ? host_addr : core_addr;
          mem_data_d    = grant_host ? host_wdata : core_wdata;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        mem_wren_d = 1'b0;
        if (op_we_q) begin
          core_ack_d = !owner_q;
          host_ack_d = owner_q;
          state_d    = DONE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (owner_q) begin
          host_rdata_d = mem_q;
        end else begin
          core_rdata_d = mem_q;
        end
        core_ack_d = !owner_q;
        host_ack_d = owner_q;
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without an ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      owner_q       <= 1'b0;
      op_we_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      core_ack_q    <= 1'b0;
      host_ack_q    <= 1'b0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      owner_q       <= owner_d;
      op_we_q       <= op_we_d;
      last_grant_q  <= last_grant_d;
      core_ack_q    <= core_ack_d;
      host_ack_q    <= host_ack_d;
      core_rdata_q  <= core_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign core_ack    = core_ack_q;
  assign host_ack    = host_ack_q;
  assign core_rdata  = core_rdata_q;
  assign host_rdata  = host_rdata_q;
  assign last_grant  = last_grant_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [11:0] core_addr = '0, core_wdata = '0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [11:0] host_addr = '0, host_wdata = '0;
  logic        core_ack, host_ack, mem_wren, busy, last_grant;
  logic [11:0] core_rdata, host_rdata, mem_address, mem_data, mem_q;
  logic        f_core_ack, f_host_ack, f_mem_wren, f_busy, f_last_grant;
  logic [11:0] f_core_rdata, f_host_rdata, f_mem_address, f_mem_data, f_mem_q;

  logic [11:0] mem   [0:4095];
  logic [11:0] f_mem [0:4095];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          host;
    bit          we;
    logic [11:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end
  always @(posedge clk) begin
    if (f_mem_wren) f_mem[f_mem_address] <= f_mem_data;
    f_mem_q <= f_mem[f_mem_address];
  end

  dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .busy(busy), .last_grant(last_grant)
  );

  dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(f_core_ack), .core_rdata(f_core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(f_host_ack), .host_rdata(f_host_rdata),
    .mem_address(f_mem_address), .mem_data(f_mem_data), .mem_wren(f_mem_wren), .mem_q(f_mem_q),
    .busy(f_busy), .last_grant(f_last_grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ack pops the oldest expected transaction
  always @(negedge clk) begin
    if (reset && (core_ack || host_ack)) begin
      chk("ack_exclusive", {31'd0, core_ack & host_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {30'd0, host_ack, core_ack}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_owner", {31'd0, host_ack}, {31'd0, e.host});
        chk("ack_cycle", cyc, e.cyc);
        if (!e.we) chk("rdata", host_ack ? host_rdata : core_rdata, e.rdata);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic txn(input bit h, input bit we, input logic [11:0] a, input logic [11:0] d,
                     input logic [11:0] exp_r);
    int c;
    bit got;
    @(negedge clk);
    if (h) begin host_req = 1; host_we = we; host_addr = a; host_wdata = d; end
    else   begin core_req = 1; core_we = we; core_addr = a; core_wdata = d; end
    c = cyc;
    exp_q.push_back('{h, we, exp_r, c + (we ? 2 : 3)});
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (h ? host_ack : core_ack) got = 1;
    end
    if (!got) chk("txn_timeout", 0, 1);
    core_req = 0;
    host_req = 0;
  endtask

  initial begin
    int c;
    int n;
    int fp_core_n;
    int fp_host_n;
    bit got;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_wren", {31'd0, mem_wren}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_core_ack", {31'd0, core_ack}, 0);
    chk("rst_host_ack", {31'd0, host_ack}, 0);
    chk("rst_last_grant", {31'd0, last_grant}, 1);
    chk("rst_mem_address", {20'd0, mem_address}, 0);
    chk("rst_core_rdata", {20'd0, core_rdata}, 0);
    reset = 1'b1;

    // 1: core write, cycle-accurate memory interface
    @(negedge clk);
    core_req = 1; core_we = 1; core_addr = 12'h005; core_wdata = 12'hABC;
    c = cyc;
    exp_q.push_back('{1'b0, 1'b1, 12'h000, c + 2});
    @(negedge clk);
    chk("t1_wren_c1", {31'd0, mem_wren}, 1);
    chk("t1_addr_c1", {20'd0, mem_address}, 32'h005);
    chk("t1_data_c1", {20'd0, mem_data}, 32'hABC);
    chk("t1_busy_c1", {31'd0, busy}, 1);
    @(negedge clk);
    chk("t1_wren_c2", {31'd0, mem_wren}, 0);
    chk("t1_busy_c2", {31'd0, busy}, 1);
    chk("t1_ack_c2", {31'd0, core_ack}, 1);
    core_req = 0;
    @(negedge clk);
    chk("t1_busy_c3", {31'd0, busy}, 0);

    // 2: core read, host untouched; then a host write used later
    txn(1'b0, 1'b0, 12'h005, 12'h000, 12'hABC);
    chk("t2_host_rdata", {20'd0, host_rdata}, 0);
    txn(1'b1, 1'b1, 12'h00A, 12'h123, 12'h000);

    // 3: simultaneous reads after reset, core first
    do_reset();
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 12'h005;
    host_req = 1; host_we = 0; host_addr = 12'h00A;
    c = cyc;
    exp_q.push_back('{1'b0, 1'b0, 12'hABC, c + 3});
    exp_q.push_back('{1'b1, 1'b0, 12'h123, c + 7});
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (core_ack) core_req = 0;
      if (host_ack) begin host_req = 0; got = 1; end
    end
    if (!got) chk("t3_timeout", 0, 1);
    core_req = 0; host_req = 0;
    chk("t3_last_grant", {31'd0, last_grant}, 1);

    // 4: continuous requests, round-robin vs fixed priority
    do_reset();
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 12'h005;
    host_req = 1; host_we = 0; host_addr = 12'h00A;
    c = cyc;
    exp_q.push_back('{1'b0, 1'b0, 12'hABC, c + 3});
    exp_q.push_back('{1'b1, 1'b0, 12'h123, c + 7});
    exp_q.push_back('{1'b0, 1'b0, 12'hABC, c + 11});
    exp_q.push_back('{1'b1, 1'b0, 12'h123, c + 15});
    n = 0; fp_core_n = 0; fp_host_n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (f_core_ack) fp_core_n++;
      if (f_host_ack) fp_host_n++;
      if (core_ack || host_ack) n++;
    end
    if (n < 4) chk("t4_timeout", n, 4);
    core_req = 0; host_req = 0;
    chk("t4_fp_core_acks", fp_core_n, 4);
    chk("t4_fp_host_acks", fp_host_n, 0);
    chk("t4_last_grant", {31'd0, last_grant}, 1);
    chk("t4_fp_last_grant", {31'd0, f_last_grant}, 0);

    // 5: host write aborted by reset during ISSUE
    @(negedge clk);
    host_req = 1; host_we = 1; host_addr = 12'h0FF; host_wdata = 12'h3FF;
    @(negedge clk);
    chk("t5_wren_issue", {31'd0, mem_wren}, 1);
    chk("t5_addr_issue", {20'd0, mem_address}, 32'h0FF);
    #1 reset = 1'b0;
    #1 chk("t5_wren_async", {31'd0, mem_wren}, 0);
    host_req = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_host_ack", {31'd0, host_ack}, 0);
    chk("t5_core_rdata", {20'd0, core_rdata}, 0);
    chk("t5_host_rdata", {20'd0, host_rdata}, 0);

    // 6: back-to-back core reads with req held across ack
    txn(1'b1, 1'b1, 12'h001, 12'h111, 12'h000);
    txn(1'b1, 1'b1, 12'h002, 12'h222, 12'h000);
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 12'h001;
    c = cyc;
    exp_q.push_back('{1'b0, 1'b0, 12'h111, c + 3});
    exp_q.push_back('{1'b0, 1'b0, 12'h222, c + 7});
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (core_ack) got = 1;
    end
    if (!got) chk("t6_timeout1", 0, 1);
    core_addr = 12'h002;
    @(negedge clk);
    chk("t6_idle_after_done", {31'd0, busy}, 0);
    @(negedge clk);
    chk("t6_busy_regrant", {31'd0, busy}, 1);
    chk("t6_addr_regrant", {20'd0, mem_address}, 32'h002);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (core_ack) got = 1;
    end
    if (!got) chk("t6_timeout2", 0, 1);
    core_req = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
